fb_cpu: RTL and testbench
=========================

# fb_cpu

Accumulator-based 10-bit CPU core with a 6-bit address space (64 words). It fetches and executes single-word instructions from a shared 64×10 synchronous block RAM, and writes results back to that RAM over a single-port interface. It sits between the system clock/reset and the `blram` memory macro; the program counter is exported for debug.

## Interface

- `ADDRESS_WIDTH`, default 6: width of MAR, PC and the instruction operand field.
- `DATA_WIDTH`, default 10: width of the data word, instruction word and accumulator.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `MDROut` input DATA_WIDTH: read data from RAM, valid one cycle after RAM samples `MAR`.
- `MDRIn` output DATA_WIDTH: write data to RAM; registered.
- `RAMWr` output 1: RAM write enable; registered.
- `MAR` output ADDRESS_WIDTH: RAM address; registered.
- `PC` output ADDRESS_WIDTH: program counter; registered.

## Operation

- RAM contract (`blram`):
  - On each rising edge, if `RAMWr`=1, write `mem[MAR] <= MDRIn`.
  - `MDROut <= mem[MAR]` every edge, so reads have 1-cycle latency.
  - RAM contents are preloaded and never cleared by `rst`.
- Instruction word:
  - Opcode is bits [9:6].
  - Operand `a` is bits [5:0], used as an address or as an immediate.
- Internal registers: `ACC` (10b), `IR` (10b), state register.
- Opcodes (M = RAM; all arithmetic is modulo 2^10, no flags):
  - 0x0 ADD: ACC += M[a]
  - 0x1 SUB: ACC −= M[a]
  - 0x2 MUL: ACC = low 10 bits of ACC×M[a]
  - 0x3 AND, 0x4 OR, 0x5 XOR: ACC = ACC op M[a]
  - 0x6 LDA: ACC = M[a]
  - 0x7 STA: M[a] = ACC
  - 0x8 LDI: ACC = zero-extended a
  - 0x9 JMP: PC = a
  - 0xA JZ: if ACC==0, PC = a
  - 0xB JNZ: if ACC!=0, PC = a
  - 0xC NOT: ACC = ~ACC
  - 0xD SHL: ACC <<= 1, zero fill
  - 0xE SHR: ACC >>= 1 logical
  - 0xF HLT
- State machine:
  - F0: MAR<=PC, RAMWr<=0. Next F1.
  - F1: wait for RAM read. Next F2.
  - F2: IR<=MDROut; PC<=PC+1, wrapping 63→0. Then decode:
    - Memory-read ops (0x0–0x6): MAR<=a; next M1.
    - STA: MAR<=a, MDRIn<=ACC, RAMWr<=1; next W.
    - LDI, NOT, SHL, SHR, and taken or not-taken jumps: execute here. A jump target overrides PC+1. Next F0.
    - HLT: next H.
  - M1: wait for RAM read. Next EX.
  - EX: ACC <= f(ACC, MDROut). Next F0.
  - W: RAMWr<=0. Next F0.
  - H: halted. PC, ACC and MAR hold; RAMWr=0. Exit only by `rst`.
- Reset values: PC=0, MAR=0, MDRIn=0, RAMWr=0, ACC=0, IR=0, state=F0.

## Timing

- Cycles per instruction, F0 to next F0:
  - LDI, NOT, shifts, jumps: 3.
  - STA: 4.
  - Memory-read ALU and LDA: 5.
- The first fetch after `rst` deasserts begins with F0 on the next edge; MAR=0 during F1.
- `RAMWr` is high for exactly one cycle per STA, with MAR and MDRIn stable in that cycle.
- A STA followed by LDA to the same address returns the new value; the W cycle guarantees the write completes first.
- `rst` during any state aborts the instruction. By the edge where `rst` is sampled, all registers take reset values and `RAMWr`=0, so no partial write occurs after that edge.
- PC wraps from 63 to 0 when executing the word at address 63.
- A jump to the instruction's own address is legal (spin).

## Test plan

- Add-store: M[0..3] = LDA 50, ADD 51, STA 52, HLT; M[50]=7, M[51]=8 → after 200 cycles, M[52]=15 and PC=4 (held, halted).
- Count loop:
  - Program: LDI 0; STA 52; loop: LDA 52; ADD 60; STA 52; SUB 61; JNZ loop; HLT.
  - Data: M[60]=1, M[61]=50.
  - Expect M[52]=50 within 10000 cycles.
- Arithmetic wrap: LDA 50 (1023), ADD 51 (1), STA 52 → M[52]=0. MUL 1023×2 → 1022. SUB 0−1 → 1023.
- Bus timing: on STA 52 with ACC=37, exactly one cycle has RAMWr=1, MAR=52, MDRIn=37. Check the cycle counts of 3, 4 and 5.
- Reset mid-instruction: assert `rst` during W and during EX → next cycle RAMWr=0, PC=0, ACC=0. The program then re-runs from address 0 with the same final result.
- Jumps and PC wrap:
  - JZ with ACC≠0 falls through.
  - JZ with ACC=0 is taken.
  - A program that reaches address 63 continues at address 0.

Source files
------------

// File: rtl/fb_cpu.sv
// Accumulator CPU core: fetches 10-bit instructions from a single-port synchronous RAM
// with one cycle of read latency, executes them against ACC, and writes results back to the RAM.
module fb_cpu #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    MDROut,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  output logic                     RAMWr,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [2:0]               dbg_state
);

  // Bus contract: there is no valid/ready handshake. The RAM samples MAR (and MDRIn when
  // RAMWr=1) on every rising edge; MDROut shows mem[MAR] one cycle later, so every read is
  // followed by a wait state (F1, M1) before the data is consumed.
  typedef enum logic [2:0] {
    S_F0 = 3'd0,
    S_F1 = 3'd1,
    S_F2 = 3'd2,
    S_M1 = 3'd3,
    S_EX = 3'd4,
    S_W  = 3'd5,
    S_H  = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDA = 4'h6;
  localparam logic [3:0] OP_STA = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JNZ = 4'hB;
  localparam logic [3:0] OP_NOT = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SHR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH-1:0]    ir_q, ir_d;
  logic [DATA_WIDTH-1:0]    mdr_in_q, mdr_in_d;
  logic                     ram_wr_q, ram_wr_d;

  logic [3:0]               f2_op;
  logic [ADDRESS_WIDTH-1:0] f2_a;
  logic [3:0]               ex_op;
  logic [2*DATA_WIDTH-1:0]  product;
  logic                     ir_unused;

  // In F2 the instruction is decoded straight off the RAM bus; IR keeps it for EX.
  assign f2_op     = MDROut[DATA_WIDTH-1 -: 4];
  assign f2_a      = MDROut[ADDRESS_WIDTH-1:0];
  assign ex_op     = ir_q[DATA_WIDTH-1 -: 4];
  assign product   = acc_q * MDROut;
  assign ir_unused = ^ir_q[DATA_WIDTH-5:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mar_d    = mar_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    mdr_in_d = mdr_in_q;
    ram_wr_d = 1'b0;
    case (state_q)
      S_F0: begin
        mar_d   = pc_q;
        state_d = S_F1;
      end
      S_F1: state_d = S_F2;
      S_F2: begin
        ir_d    = MDROut;
        pc_d    = pc_q + ADDRESS_WIDTH'(1);
        state_d = S_F0;
        case (f2_op)
          OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_LDA: begin
            mar_d   = f2_a;
            state_d = S_M1;
          end
          OP_STA: begin
            mar_d    = f2_a;
            mdr_in_d = acc_q;
            ram_wr_d = 1'b1;
            state_d  = S_W;
          end
          OP_LDI: acc_d = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, f2_a};
          OP_JMP: pc_d = f2_a;
          OP_JZ:  if (acc_q == '0) pc_d = f2_a;
          OP_JNZ: if (acc_q != '0) pc_d = f2_a;
          OP_NOT: acc_d = ~acc_q;
          OP_SHL: acc_d = {acc_q[DATA_WIDTH-2:0], 1'b0};
          OP_SHR: acc_d = {1'b0, acc_q[DATA_WIDTH-1:1]};
          OP_HLT: state_d = S_H;
          default: state_d = S_F0;
        endcase
      end
      S_M1: state_d = S_EX;
      S_EX: begin
        state_d = S_F0;
        case (ex_op)
          OP_ADD:  acc_d = acc_q + MDROut;
          OP_SUB:  acc_d = acc_q - MDROut;
          OP_MUL:  acc_d = product[DATA_WIDTH-1:0];
          OP_AND:  acc_d = acc_q & MDROut;
          OP_OR:   acc_d = acc_q | MDROut;
          OP_XOR:  acc_d = acc_q ^ MDROut;
          OP_LDA:  acc_d = MDROut;
          default: acc_d = acc_q;
        endcase
      end
      S_W:  state_d = S_F0;
      S_H:  state_d = S_H;
      default: state_d = S_F0;
    endcase
  end

  // Reset wins over every state, including W, so RAMWr is low right after the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_F0;
      pc_q     <= '0;
      mar_q    <= '0;
      acc_q    <= '0;
      ir_q     <= '0;
      mdr_in_q <= '0;
      ram_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      acc_q    <= acc_d;
      ir_q     <= ir_d;
      mdr_in_q <= mdr_in_d;
      ram_wr_q <= ram_wr_d;
    end
  end

  assign MDRIn     = mdr_in_q;
  assign RAMWr     = ram_wr_q;
  assign MAR       = mar_q;
  assign PC        = pc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_cpu.sv
// Bench for fb_cpu: a behavioural 64x10 RAM, table-driven single-op programs and
// hand-written sequences for bus timing, loops, jumps, PC wrap and mid-instruction reset.
module tb_fb_cpu;

  localparam logic [2:0] ST_F0 = 3'd0;
  localparam logic [2:0] ST_F1 = 3'd1;
  localparam logic [2:0] ST_EX = 3'd4;
  localparam logic [2:0] ST_W  = 3'd5;
  localparam logic [2:0] ST_H  = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] MDROut;
  logic [9:0] MDRIn;
  logic       RAMWr;
  logic [5:0] MAR;
  logic [5:0] PC;
  logic [2:0] dbg_state;

  logic [9:0] mem [64];
  logic [9:0] img [64];
  logic       load_req = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0] op;
    logic [5:0] a;
    logic [9:0] m50;
    logic [9:0] acc0;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [14];

  fb_cpu #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .MDROut    (MDROut),
    .MDRIn     (MDRIn),
    .RAMWr     (RAMWr),
    .MAR       (MAR),
    .PC        (PC),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 64; k++) mem[k] <= img[k];
    end else if (RAMWr === 1'b1) begin
      mem[MAR] <= MDRIn;
    end
    MDROut <= mem[MAR];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [9:0] ins(input logic [3:0] op, input logic [5:0] a);
    return {op, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int k = 0; k < 64; k++) img[k] = '0;
  endtask

  // Holds reset, copies img into the RAM, and returns at the negedge where rst drops.
  task automatic start_prog();
    rst = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, input string name);
    int n = 0;
    while (dbg_state !== ST_H && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, dbg_state, ST_H);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, dbg_state, s);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc, wr_cnt, wr52;
    int f0_q[$];

    // op, operand, M[50], initial ACC (loaded from M[51]), expected ACC stored to M[52]
    vecs[0]  = '{4'h0, 6'd50, 10'd1,   10'd1023, 10'd0};
    vecs[1]  = '{4'h0, 6'd50, 10'd8,   10'd7,    10'd15};
    vecs[2]  = '{4'h1, 6'd50, 10'd1,   10'd0,    10'd1023};
    vecs[3]  = '{4'h1, 6'd50, 10'd37,  10'd100,  10'd63};
    vecs[4]  = '{4'h2, 6'd50, 10'd2,   10'd1023, 10'd1022};
    vecs[5]  = '{4'h2, 6'd50, 10'd40,  10'd25,   10'd1000};
    vecs[6]  = '{4'h3, 6'd50, 10'h0FF, 10'h3F0,  10'h0F0};
    vecs[7]  = '{4'h4, 6'd50, 10'h00F, 10'h300,  10'h30F};
    vecs[8]  = '{4'h5, 6'd50, 10'h3FF, 10'h2AA,  10'h155};
    vecs[9]  = '{4'h6, 6'd50, 10'd512, 10'd5,    10'd512};
    vecs[10] = '{4'h8, 6'd45, 10'd0,   10'd999,  10'd45};
    vecs[11] = '{4'hC, 6'd0,  10'd0,   10'h0F0,  10'h30F};
    vecs[12] = '{4'hD, 6'd0,  10'd0,   10'h201,  10'h002};
    vecs[13] = '{4'hE, 6'd0,  10'd0,   10'h201,  10'h100};

    // Reset values while rst is held
    clear_img();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pc", PC, 0);
    check("rst_mar", MAR, 0);
    check("rst_mdrin", MDRIn, 0);
    check("rst_ramwr", RAMWr, 0);
    check("rst_state", dbg_state, ST_F0);

    // Table-driven ALU / immediate ops: LDA 51; OP a; STA 52; HLT
    for (int i = 0; i < 14; i++) begin
      clear_img();
      img[0]  = ins(4'h6, 6'd51);
      img[1]  = ins(vecs[i].op, vecs[i].a);
      img[2]  = ins(4'h7, 6'd52);
      img[3]  = ins(4'hF, 6'd0);
      img[50] = vecs[i].m50;
      img[51] = vecs[i].acc0;
      img[52] = 10'd682;
      start_prog();
      run_to_halt(200, $sformatf("vec%0d_halt", i));
      check($sformatf("vec%0d_m52", i), mem[52], vecs[i].exp);
      check($sformatf("vec%0d_pc", i), PC, 4);
    end

    // Bus timing: LDI 37; STA 52; LDA 52; STA 53; HLT
    clear_img();
    img[0] = ins(4'h8, 6'd37);
    img[1] = ins(4'h7, 6'd52);
    img[2] = ins(4'h6, 6'd52);
    img[3] = ins(4'h7, 6'd53);
    img[4] = ins(4'hF, 6'd0);
    start_prog();
    cyc = 0; wr_cnt = 0; wr52 = 0;
    f0_q.delete();
    while (dbg_state !== ST_H && cyc < 100) begin
      if (dbg_state == ST_F0) f0_q.push_back(cyc);
      if (cyc == 1) begin
        check("first_f1_state", dbg_state, ST_F1);
        check("first_f1_mar", MAR, 0);
      end
      if (RAMWr === 1'b1) begin
        wr_cnt++;
        if (MAR == 6'd52) begin
          wr52++;
          check("sta_mdrin", MDRIn, 37);
        end
      end
      @(negedge clk);
      cyc++;
    end
    exp_q.delete();
    exp_q.push_back(3);
    exp_q.push_back(4);
    exp_q.push_back(5);
    exp_q.push_back(4);
    check("f0_count", f0_q.size(), 5);
    for (int i = 0; i + 1 < f0_q.size() && exp_q.size() > 0; i++)
      check($sformatf("cpi_%0d", i), f0_q[i+1] - f0_q[i], exp_q.pop_front());
    check("wr_cycles", wr_cnt, 2);
    check("wr52_cycles", wr52, 1);
    check("sta_lda_fwd", mem[53], 37);

    // Count loop
    clear_img();
    img[0]  = ins(4'h8, 6'd0);
    img[1]  = ins(4'h7, 6'd52);
    img[2]  = ins(4'h6, 6'd52);
    img[3]  = ins(4'h0, 6'd60);
    img[4]  = ins(4'h7, 6'd52);
    img[5]  = ins(4'h1, 6'd61);
    img[6]  = ins(4'hB, 6'd2);
    img[7]  = ins(4'hF, 6'd0);
    img[60] = 10'd1;
    img[61] = 10'd50;
    start_prog();
    run_to_halt(10000, "loop_halt");
    check("loop_m52", mem[52], 50);
    check("loop_pc", PC, 8);

    // JZ not taken then taken
    clear_img();
    img[0] = ins(4'h8, 6'd5);
    img[1] = ins(4'hA, 6'd5);
    img[2] = ins(4'h8, 6'd0);
    img[3] = ins(4'hA, 6'd6);
    img[4] = ins(4'hF, 6'd0);
    img[5] = ins(4'hF, 6'd0);
    img[6] = ins(4'h8, 6'd63);
    img[7] = ins(4'h7, 6'd52);
    img[8] = ins(4'hF, 6'd0);
    start_prog();
    run_to_halt(200, "jz_halt");
    check("jz_pc", PC, 9);
    check("jz_m52", mem[52], 63);

    // JMP to 62, execute 62 and 63, wrap to 0, JNZ taken
    clear_img();
    img[0]  = ins(4'hB, 6'd10);
    img[1]  = ins(4'h9, 6'd62);
    img[10] = ins(4'h7, 6'd52);
    img[11] = ins(4'hF, 6'd0);
    img[62] = ins(4'h8, 6'd9);
    img[63] = ins(4'hD, 6'd0);
    start_prog();
    run_to_halt(200, "wrap_halt");
    check("wrap_m52", mem[52], 18);
    check("wrap_pc", PC, 12);

    // Jump to own address spins forever
    clear_img();
    img[0] = ins(4'h9, 6'd0);
    start_prog();
    repeat (30) @(negedge clk);
    check("spin_pc", PC, 0);
    check("spin_not_halted", dbg_state == ST_H, 0);

    // Reset during W, then rerun: LDA 50; ADD 51; STA 52; HLT
    clear_img();
    img[0]  = ins(4'h6, 6'd50);
    img[1]  = ins(4'h0, 6'd51);
    img[2]  = ins(4'h7, 6'd52);
    img[3]  = ins(4'hF, 6'd0);
    img[50] = 10'd7;
    img[51] = 10'd8;
    start_prog();
    wait_state(ST_W, 100, "reach_w");
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ramwr", RAMWr, 0);
    check("rstw_pc", PC, 0);
    check("rstw_mar", MAR, 0);
    check("rstw_state", dbg_state, ST_F0);
    rst = 1'b0;
    run_to_halt(200, "rstw_halt");
    check("rstw_m52", mem[52], 15);
    check("rstw_final_pc", PC, 4);

    // Reset during the second EX: ADD 50; ADD 51; STA 52; HLT needs ACC cleared to give 15
    clear_img();
    img[0]  = ins(4'h0, 6'd50);
    img[1]  = ins(4'h0, 6'd51);
    img[2]  = ins(4'h7, 6'd52);
    img[3]  = ins(4'hF, 6'd0);
    img[50] = 10'd7;
    img[51] = 10'd8;
    start_prog();
    wait_state(ST_EX, 100, "reach_ex1");
    @(negedge clk);
    wait_state(ST_EX, 100, "reach_ex2");
    rst = 1'b1;
    @(negedge clk);
    check("rstex_ramwr", RAMWr, 0);
    check("rstex_pc", PC, 0);
    check("rstex_state", dbg_state, ST_F0);
    rst = 1'b0;
    run_to_halt(200, "rstex_halt");
    check("rstex_m52", mem[52], 15);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
